sprite_pixel_compositor: RTL and testbench
==========================================

// Module: sprite_pixel_compositor
// PURPOSE
// - Downstream of the sprite movement/print stage. Consumes the enable/address/element outputs of two
//   sprite printers (A = player, B = second sprite), issues sprite-memory reads, and aligns the returned
//   data with delayed pixel coordinates and the video-enable signal.
// - Applies colour-key transparency, fixed priority and a background colour, and outputs one registered
//   RGB pixel per clk to the VGA output stage.
// - Flags per-frame sprite overlap (A and B both opaque at one pixel) for game logic.
// PARAMETERS
// ADDRESS_MEMORY      10      sprite memory address width
// QTD_MEMORY_ELEMENT  4       memory banks per sprite; element inputs are one-hot bank selects
// COLOR_W             9       pixel colour width (RGB 3-3-3)
// MEM_LATENCY         1       sprite memory read latency in clk cycles; legal range 1..4
// COLOR_KEY           9'h1C7  transparent colour value
// BG_COLOR            9'h000  colour where no opaque sprite is present
// PORTS
// clk            in   1                         pixel clock, rising edge
// reset          in   1                         asynchronous, active-low reset
// pixel_x        in   11                        current pixel column
// pixel_y        in   10                        current pixel row
// videoEnable    in   1                         active-video qualifier
// enable_a       in   1                         sprite A covers the current pixel
// address_a      in   ADDRESS_MEMORY            sprite A memory address
// element_a      in   QTD_MEMORY_ELEMENT        sprite A bank select (one-hot)
// enable_b       in   1                         sprite B covers the current pixel
// address_b      in   ADDRESS_MEMORY            sprite B memory address
// element_b      in   QTD_MEMORY_ELEMENT        sprite B bank select (one-hot)
// mem_addr_a     out  ADDRESS_MEMORY            sprite A read address (combinational copy of address_a)
// mem_data_a     in   QTD_MEMORY_ELEMENT*COLOR_W sprite A read data, one COLOR_W slice per bank, MEM_LATENCY after addr
// mem_addr_b     out  ADDRESS_MEMORY            sprite B read address (combinational copy of address_b)
// mem_data_b     in   QTD_MEMORY_ELEMENT*COLOR_W sprite B read data, one COLOR_W slice per bank, MEM_LATENCY after addr
// rgb            out  COLOR_W                   composited pixel colour (registered)
// video_out      out  1                         videoEnable delayed to align with rgb
// pixel_x_out    out  11                        pixel_x delayed to align with rgb
// pixel_y_out    out  10                        pixel_y delayed to align with rgb
// frame_tick     out  1                         1-cycle pulse when pixel_x_out==0 && pixel_y_out==0
// collision      out  1                         overlap result of the previous frame, held one frame
// BEHAVIOUR
// - reset low: asynchronous clear. All outputs, the delay pipeline and the hit accumulator go to 0;
//   rgb = 0, not BG_COLOR. Reset release is synchronous to clk.
// - Reset mid-frame: the pipeline flushes. Outputs stay 0 until valid data has refilled the
//   MEM_LATENCY+1 stages.
// - Pipeline: pixel_x, pixel_y, videoEnable, enable_a/b and element_a/b are delayed MEM_LATENCY stages
//   to align with mem_data. Compositing is then registered once.
// - Total latency: input at cycle N -> rgb, video_out and pixel_x_out/pixel_y_out at N+MEM_LATENCY+1.
// - Slice select: the set bit of the delayed element picks slice [k*COLOR_W +: COLOR_W].
//   - element == 0: sprite treated as transparent.
//   - Multiple bits set: lowest set index wins.
// - Opacity: opaque_x = delayed enable_x && selected slice != COLOR_KEY.
// - Output colour:
//   - delayed videoEnable == 0 -> rgb = 0
//   - else opaque_a -> slice A (A has priority over B)
//   - else opaque_b -> slice B
//   - else BG_COLOR
// - Hit accumulator: sets when delayed videoEnable && opaque_a && opaque_b. It is sticky until a frame boundary.
// - Frame boundary (delayed x==0 && y==0, evaluated on the compositing edge):
//   - frame_tick = 1
//   - collision <= accumulator
//   - accumulator <= overlap of the current pixel only (the first pixel counts toward the new frame)
// - Two consecutive cycles at (0,0) produce two ticks. Each tick transfers and restarts as above.
// - No backpressure. A new pixel is accepted every cycle and every input change propagates.
// - Coordinate widths are passed through unchanged. No arithmetic is performed on them.
// TESTING
// - T1: hold reset low 3 cycles with random inputs -> rgb=0, video_out=0, collision=0, frame_tick=0;
//   release -> first valid rgb appears 2 cycles later (MEM_LATENCY=1).
// - T2: videoEnable=1, enable_a=1, element_a=4'b0010, mem_data_a slice1=9'h0F0 ->
//   rgb=9'h0F0 exactly MEM_LATENCY+1 cycles later; pixel_x_out matches the input pixel_x.
// - T3: slice A = COLOR_KEY, sprite B opaque 9'h038 -> rgb=9'h038; both transparent -> rgb=BG_COLOR;
//   both opaque -> rgb = slice A.
// - T4: one overlapping opaque pixel at (100,200) in frame 1, none in frame 2 ->
//   collision=1 after the frame-2 tick, collision=0 after the frame-3 tick.
// - T5: element_a=4'b0000 with enable_a=1 -> background shown;
//   element_a=4'b0110 -> slice 1 used.
// - T6: rerun T2 and T4 with MEM_LATENCY=3 -> latency = 4 cycles, same colours;
//   reset asserted mid-frame -> collision cleared, outputs 0 until refill.

Source files
------------

// File: rtl/sprite_pixel_compositor_if.sv
// Pixel/sprite stream into the compositor, sprite-memory read ports and the composited pixel out.
// Upstream side (master) drives coordinates, sprite enables and memory data; the compositor is the slave.
interface sprite_pixel_compositor_if #(
  parameter int ADDRESS_MEMORY     = 10,
  parameter int QTD_MEMORY_ELEMENT = 4,
  parameter int COLOR_W            = 9
);
  logic [10:0]                             pixel_x;
  logic [9:0]                              pixel_y;
  logic                                    videoEnable;
  logic                                    enable_a;
  logic [ADDRESS_MEMORY-1:0]               address_a;
  logic [QTD_MEMORY_ELEMENT-1:0]           element_a;
  logic                                    enable_b;
  logic [ADDRESS_MEMORY-1:0]               address_b;
  logic [QTD_MEMORY_ELEMENT-1:0]           element_b;
  logic [ADDRESS_MEMORY-1:0]               mem_addr_a;
  logic [QTD_MEMORY_ELEMENT*COLOR_W-1:0]   mem_data_a;
  logic [ADDRESS_MEMORY-1:0]               mem_addr_b;
  logic [QTD_MEMORY_ELEMENT*COLOR_W-1:0]   mem_data_b;
  logic [COLOR_W-1:0]                      rgb;
  logic                                    video_out;
  logic [10:0]                             pixel_x_out;
  logic [9:0]                              pixel_y_out;
  logic                                    frame_tick;
  logic                                    collision;

  modport master (
    output pixel_x, pixel_y, videoEnable,
    output enable_a, address_a, element_a, enable_b, address_b, element_b,
    output mem_data_a, mem_data_b,
    input  mem_addr_a, mem_addr_b,
    input  rgb, video_out, pixel_x_out, pixel_y_out, frame_tick, collision
  );

  modport slave (
    input  pixel_x, pixel_y, videoEnable,
    input  enable_a, address_a, element_a, enable_b, address_b, element_b,
    input  mem_data_a, mem_data_b,
    output mem_addr_a, mem_addr_b,
    output rgb, video_out, pixel_x_out, pixel_y_out, frame_tick, collision
  );
endinterface

// File: rtl/sprite_pixel_compositor.sv
// Two-sprite compositor: colour-key transparency, A-over-B priority, background fill, per-frame overlap flag.
// Latency MEM_LATENCY+1 clk from inputs to rgb; no backpressure, one pixel accepted every clk.
module sprite_pixel_compositor #(
  parameter int                ADDRESS_MEMORY     = 10,
  parameter int                QTD_MEMORY_ELEMENT = 4,
  parameter int                COLOR_W            = 9,
  parameter int                MEM_LATENCY        = 1,
  parameter logic [COLOR_W-1:0] COLOR_KEY         = 9'h1C7,
  parameter logic [COLOR_W-1:0] BG_COLOR          = 9'h000
) (
  input logic                     clk,
  input logic                     reset,
  sprite_pixel_compositor_if.slave bus
);

  typedef struct packed {
    logic                          vld;
    logic [10:0]                   x;
    logic [9:0]                    y;
    logic                          ve;
    logic                          en_a;
    logic [QTD_MEMORY_ELEMENT-1:0] el_a;
    logic                          en_b;
    logic [QTD_MEMORY_ELEMENT-1:0] el_b;
  } stage_t;

  // Bit COLOR_W flags that some bank was selected; lowest set bank wins.
  function automatic logic [COLOR_W:0] pick_slice(
    input logic [QTD_MEMORY_ELEMENT-1:0]         el,
    input logic [QTD_MEMORY_ELEMENT*COLOR_W-1:0] data
  );
    logic [COLOR_W:0] res;
    res = '0;
    for (int k = QTD_MEMORY_ELEMENT - 1; k >= 0; k--) begin
      if (el[k]) res = {1'b1, data[k*COLOR_W +: COLOR_W]};
    end
    return res;
  endfunction

  stage_t             pipe [MEM_LATENCY];
  stage_t             in_st;
  stage_t             st;
  logic [COLOR_W:0]   sel_a;
  logic [COLOR_W:0]   sel_b;
  logic               opaque_a;
  logic               opaque_b;
  logic               overlap;
  logic               boundary;
  logic [COLOR_W-1:0] color_nxt;

  logic [COLOR_W-1:0] rgb_q;
  logic               video_q;
  logic [10:0]        x_q;
  logic [9:0]         y_q;
  logic               tick_q;
  logic               collision_q;
  logic               hit_acc;

  assign bus.mem_addr_a = bus.address_a;
  assign bus.mem_addr_b = bus.address_b;

  always_comb begin
    in_st      = '0;
    in_st.vld  = 1'b1;
    in_st.x    = bus.pixel_x;
    in_st.y    = bus.pixel_y;
    in_st.ve   = bus.videoEnable;
    in_st.en_a = bus.enable_a;
    in_st.el_a = bus.element_a;
    in_st.en_b = bus.enable_b;
    in_st.el_b = bus.element_b;
  end

  // vld keeps the zeroed stages left by reset from looking like a pixel at (0,0).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MEM_LATENCY; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= in_st;
      for (int i = 1; i < MEM_LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign st = pipe[MEM_LATENCY-1];

  always_comb begin
    sel_a     = pick_slice(st.el_a, bus.mem_data_a);
    sel_b     = pick_slice(st.el_b, bus.mem_data_b);
    opaque_a  = st.en_a && sel_a[COLOR_W] && (sel_a[COLOR_W-1:0] != COLOR_KEY);
    opaque_b  = st.en_b && sel_b[COLOR_W] && (sel_b[COLOR_W-1:0] != COLOR_KEY);
    overlap   = st.ve && opaque_a && opaque_b;
    boundary  = st.vld && (st.x == '0) && (st.y == '0);
    color_nxt = BG_COLOR;
    if (!st.ve)        color_nxt = '0;
    else if (opaque_a) color_nxt = sel_a[COLOR_W-1:0];
    else if (opaque_b) color_nxt = sel_b[COLOR_W-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rgb_q       <= '0;
      video_q     <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      tick_q      <= 1'b0;
      collision_q <= 1'b0;
      hit_acc     <= 1'b0;
    end else begin
      rgb_q   <= color_nxt;
      video_q <= st.ve;
      x_q     <= st.x;
      y_q     <= st.y;
      tick_q  <= boundary;
      // The boundary pixel itself opens the new frame's accumulation.
      if (boundary) begin
        collision_q <= hit_acc;
        hit_acc     <= overlap;
      end else begin
        hit_acc     <= hit_acc | overlap;
      end
    end
  end

  assign bus.rgb         = rgb_q;
  assign bus.video_out   = video_q;
  assign bus.pixel_x_out = x_q;
  assign bus.pixel_y_out = y_q;
  assign bus.frame_tick  = tick_q;
  assign bus.collision   = collision_q;

endmodule

// File: tb/tb_sprite_pixel_compositor.sv
// Bench for sprite_pixel_compositor: two instances (read latency 1 and 3) share one stimulus stream
// and are compared every cycle against a per-pixel expectation table plus a frame-level overlap model.
module tb_sprite_pixel_compositor;
  localparam logic [8:0] KEY = 9'h1C7;
  localparam logic [8:0] BG  = 9'h000;
  localparam int         MAXC = 4096;

  logic clk;
  logic reset;

  sprite_pixel_compositor_if #(.ADDRESS_MEMORY(10), .QTD_MEMORY_ELEMENT(4), .COLOR_W(9)) if0 ();
  sprite_pixel_compositor_if #(.ADDRESS_MEMORY(10), .QTD_MEMORY_ELEMENT(4), .COLOR_W(9)) if1 ();

  sprite_pixel_compositor #(.MEM_LATENCY(1)) u_lat1 (.clk(clk), .reset(reset), .bus(if0));
  sprite_pixel_compositor #(.MEM_LATENCY(3)) u_lat3 (.clk(clk), .reset(reset), .bus(if1));

  // shared stimulus
  logic [10:0] px;
  logic [9:0]  py;
  logic        ve, ea, eb;
  logic [9:0]  aa, ab;
  logic [3:0]  la, lb;

  assign if0.pixel_x = px;  assign if1.pixel_x = px;
  assign if0.pixel_y = py;  assign if1.pixel_y = py;
  assign if0.videoEnable = ve;  assign if1.videoEnable = ve;
  assign if0.enable_a = ea;  assign if1.enable_a = ea;
  assign if0.address_a = aa; assign if1.address_a = aa;
  assign if0.element_a = la; assign if1.element_a = la;
  assign if0.enable_b = eb;  assign if1.enable_b = eb;
  assign if0.address_b = ab; assign if1.address_b = ab;
  assign if0.element_b = lb; assign if1.element_b = lb;

  // sprite memories with 1- and 3-cycle read latency
  logic [35:0] mem_a [1024];
  logic [35:0] mem_b [1024];
  logic [35:0] d1a, d1b;
  logic [35:0] d3a [3];
  logic [35:0] d3b [3];

  always @(posedge clk) begin
    d1a    <= mem_a[if0.mem_addr_a];
    d1b    <= mem_b[if0.mem_addr_b];
    d3a[0] <= mem_a[if1.mem_addr_a];
    d3b[0] <= mem_b[if1.mem_addr_b];
    d3a[1] <= d3a[0];  d3a[2] <= d3a[1];
    d3b[1] <= d3b[0];  d3b[2] <= d3b[1];
  end

  assign if0.mem_data_a = d1a;
  assign if0.mem_data_b = d1b;
  assign if1.mem_data_a = d3a[2];
  assign if1.mem_data_b = d3b[2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // expectation table, indexed by the clock edge that captures the pixel
  logic [8:0]  r_rgb [MAXC];
  logic        r_ve  [MAXC];
  logic        r_ov  [MAXC];
  logic [10:0] r_x   [MAXC];
  logic [9:0]  r_y   [MAXC];

  int   checks = 0;
  int   errors = 0;
  int   edge_n = 0;
  int   last_rst = 0;
  logic acc [2];
  logic col [2];

  function automatic logic [9:0] tb_sel(input logic [3:0] el, input logic [35:0] d);
    for (int k = 0; k < 4; k++)
      if (el[k]) return {1'b1, d[9*k +: 9]};
    return 10'd0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, edge_n, obs, exp);
    end
  endtask

  task automatic chk(input int d, input int lat, input logic [8:0] o_rgb, input logic o_ve,
                     input logic [10:0] o_x, input logic [9:0] o_y, input logic o_tk, input logic o_col);
    int          k;
    logic [8:0]  e_rgb;
    logic        e_ve, e_tk, bnd;
    logic [10:0] e_x;
    logic [9:0]  e_y;
    k = edge_n - lat;
    e_rgb = '0; e_ve = 1'b0; e_x = '0; e_y = '0; e_tk = 1'b0;
    if (last_rst == edge_n) begin
      acc[d] = 1'b0;
      col[d] = 1'b0;
    end else if (k > last_rst) begin
      e_rgb = r_rgb[k]; e_ve = r_ve[k]; e_x = r_x[k]; e_y = r_y[k];
      bnd = (r_x[k] == 0) && (r_y[k] == 0);
      e_tk = bnd;
      if (bnd) begin
        col[d] = acc[d];
        acc[d] = r_ov[k];
      end else begin
        acc[d] = acc[d] | r_ov[k];
      end
    end
    check($sformatf("L%0d_rgb", lat), 32'(o_rgb), 32'(e_rgb));
    check($sformatf("L%0d_video_out", lat), 32'(o_ve), 32'(e_ve));
    check($sformatf("L%0d_pixel_x_out", lat), 32'(o_x), 32'(e_x));
    check($sformatf("L%0d_pixel_y_out", lat), 32'(o_y), 32'(e_y));
    check($sformatf("L%0d_frame_tick", lat), 32'(o_tk), 32'(e_tk));
    check($sformatf("L%0d_collision", lat), 32'(o_col), 32'(col[d]));
  endtask

  task automatic cycle();
    @(posedge clk);
    edge_n++;
    if (!reset) last_rst = edge_n;
    #1;
    chk(0, 1, if0.rgb, if0.video_out, if0.pixel_x_out, if0.pixel_y_out, if0.frame_tick, if0.collision);
    chk(1, 3, if1.rgb, if1.video_out, if1.pixel_x_out, if1.pixel_y_out, if1.frame_tick, if1.collision);
  endtask

  task automatic drive(input logic r, input logic [10:0] x, input logic [9:0] y, input logic v,
                       input logic ena, input logic [9:0] adra, input logic [3:0] ela,
                       input logic enb, input logic [9:0] adrb, input logic [3:0] elb);
    int         k;
    logic [9:0] sa, sb;
    logic       oa, ob;
    reset = r; px = x; py = y; ve = v;
    ea = ena; aa = adra; la = ela; eb = enb; ab = adrb; lb = elb;
    k  = edge_n + 1;
    sa = tb_sel(ela, mem_a[adra]);
    sb = tb_sel(elb, mem_b[adrb]);
    oa = ena && sa[9] && (sa[8:0] != KEY);
    ob = enb && sb[9] && (sb[8:0] != KEY);
    r_rgb[k] = !v ? 9'h000 : oa ? sa[8:0] : ob ? sb[8:0] : BG;
    r_ov[k]  = v && oa && ob;
    r_ve[k]  = v;
    r_x[k]   = x;
    r_y[k]   = y;
    cycle();
  endtask

  task automatic pix(input logic [10:0] x, input logic [9:0] y, input logic v,
                     input logic ena, input logic [9:0] adra, input logic [3:0] ela,
                     input logic enb, input logic [9:0] adrb, input logic [3:0] elb);
    drive(1'b1, x, y, v, ena, adra, ela, enb, adrb, elb);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) pix(11'd9, 10'd9, 1'b0, 1'b0, 10'd0, 4'd0, 1'b0, 10'd0, 4'd0);
  endtask

  task automatic rand_pix(input logic r);
    drive(r, 11'($urandom_range(0, 2)), 10'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 9) < 7), 10'($urandom_range(0, 15)), 4'($urandom),
          ($urandom_range(0, 9) < 7), 10'($urandom_range(0, 15)), 4'($urandom));
  endtask

  initial begin
    acc[0] = 1'b0; acc[1] = 1'b0; col[0] = 1'b0; col[1] = 1'b0;
    for (int i = 0; i < 1024; i++)
      for (int s = 0; s < 4; s++) begin
        mem_a[i][9*s +: 9] = ($urandom_range(0, 3) == 0) ? KEY : 9'($urandom);
        mem_b[i][9*s +: 9] = ($urandom_range(0, 3) == 0) ? KEY : 9'($urandom);
      end
    // directed colours
    mem_a[5][9 +: 9]  = 9'h0F0;
    mem_a[5][0 +: 9]  = 9'h00F;
    mem_a[5][18 +: 9] = 9'h1AA;
    mem_a[7][9 +: 9]  = KEY;
    mem_b[6][0 +: 9]  = 9'h038;
    mem_b[8][0 +: 9]  = KEY;

    // reset held low with random inputs
    for (int i = 0; i < 3; i++) rand_pix(1'b0);

    // first pixel after release: A opaque via bank 1
    pix(11'd42, 10'd17, 1'b1, 1'b1, 10'd5, 4'b0010, 1'b0, 10'd0, 4'd0);
    idle(1);
    // A keyed out, B shows; both transparent; both opaque
    pix(11'd43, 10'd17, 1'b1, 1'b1, 10'd7, 4'b0010, 1'b1, 10'd6, 4'b0001);
    pix(11'd44, 10'd17, 1'b1, 1'b1, 10'd7, 4'b0010, 1'b1, 10'd8, 4'b0001);
    pix(11'd45, 10'd17, 1'b1, 1'b1, 10'd5, 4'b0010, 1'b1, 10'd6, 4'b0001);
    // no bank selected, then multiple banks selected
    pix(11'd46, 10'd17, 1'b1, 1'b1, 10'd5, 4'b0000, 1'b0, 10'd6, 4'b0001);
    pix(11'd47, 10'd17, 1'b1, 1'b1, 10'd5, 4'b0110, 1'b0, 10'd6, 4'b0001);
    pix(11'd48, 10'd17, 1'b0, 1'b1, 10'd5, 4'b0010, 1'b1, 10'd6, 4'b0001);
    idle(4);

    // frame 1 with one overlap, frame 2 clean, frame 3 start
    pix(11'd0,   10'd0,   1'b1, 1'b1, 10'd5, 4'b0010, 1'b0, 10'd6, 4'b0001);
    pix(11'd100, 10'd200, 1'b1, 1'b1, 10'd5, 4'b0010, 1'b1, 10'd6, 4'b0001);
    pix(11'd101, 10'd200, 1'b1, 1'b1, 10'd5, 4'b0010, 1'b0, 10'd6, 4'b0001);
    idle(2);
    pix(11'd0,   10'd0,   1'b1, 1'b0, 10'd5, 4'b0010, 1'b1, 10'd6, 4'b0001);
    pix(11'd100, 10'd200, 1'b1, 1'b1, 10'd5, 4'b0010, 1'b0, 10'd6, 4'b0001);
    idle(2);
    pix(11'd0,   10'd0,   1'b1, 1'b0, 10'd5, 4'b0010, 1'b0, 10'd6, 4'b0001);
    pix(11'd0,   10'd0,   1'b1, 1'b1, 10'd5, 4'b0010, 1'b1, 10'd6, 4'b0001);
    idle(1);
    pix(11'd0,   10'd0,   1'b1, 1'b0, 10'd5, 4'b0010, 1'b0, 10'd6, 4'b0001);
    idle(5);

    // randomized traffic with a mid-frame reset
    for (int i = 0; i < 700; i++) rand_pix((i >= 350 && i < 352) ? 1'b0 : 1'b1);
    idle(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
